// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit producing the HI/LO pair.
// Covers mult, multu, div, divu (op = 00/01/10/11) plus mthi/mtlo writes.
// Operations take WIDTH+1 cycles after the start edge: WIDTH CALC steps + FIX.
// Optional feature: define MULDIV_ABORT_EN to add an 'abort' input that
// flushes an in-flight operation without touching HI/LO.
//
// Handshake: 'start' is only sampled while busy=0; while busy=1 start,
// hi_we and lo_we are ignored. 'done' pulses for one cycle in the cycle
// HI/LO first show a new operation result; busy is already low then.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand |a| or divisor |b|
  logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or {remainder, quotient}
  logic               neg_q, neg_d;       // negate product / quotient
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               abort_w;
`ifdef MULDIV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  logic               signed_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes and one radix-2 step of each algorithm.
  // The magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude, so no extra bit is needed.
  always_comb begin
    signed_in = ~op[0];
    a_mag     = (signed_in && srca[WIDTH-1]) ? (~srca + WIDTH'(1)) : srca;
    b_mag     = (signed_in && srcb[WIDTH-1]) ? (~srcb + WIDTH'(1)) : srcb;
    // Shift-add: multiplier sits in the low half and shifts out LSB first.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // Restoring divide: partial remainder in the high half, dividend bits
    // shift in from the low half, quotient bits fill the low half.
    // When rem_sh >= divisor the true difference fits WIDTH bits, so a
    // WIDTH-bit subtract of the low bits gives it exactly.
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub   = rem_sh[WIDTH-1:0] - opnd_q;
    if (rem_sh >= {1'b0, opnd_q})
      div_next = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
    else
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    prod_fix  = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    quo_fix   = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                          : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the IDLE -> CALC -> FIX -> IDLE sequence.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          opnd_d    = op[1] ? b_mag : a_mag;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          neg_d     = signed_in & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          neg_rem_d = signed_in & op[1] & srca[WIDTH-1];
          div0_d    = op[1] & (srcb == '0);
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_CALC;
        end else begin
          if (hi_we) hi_d = wd;
          if (lo_we) lo_d = wd;
        end
      end
      S_CALC: begin
        if (abort_w) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = op_q[1] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!abort_w) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            // Divide by zero: remainder path already yields the signed dividend.
            hi_d = rem_fix;
            lo_d = div0_q ? '1 : quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed and random mult/div operations,
// mthi/mtlo writes, busy-time interference, mid-operation reset and
// (with MULDIV_ABORT_EN) abort.
module tb_muldiv_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
`ifdef MULDIV_ABORT_EN
  logic        abort;
`endif
  logic [31:0] srca, srcb, wd;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
`ifdef MULDIV_ABORT_EN
    .abort  (abort),
`endif
    .srca   (srca),
    .srcb   (srcb),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wd     (wd),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];     // expected {hi, lo} per operation
  logic [31:0] mdl_hi, mdl_lo;
  int          err_cnt = 0;
  int          chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference results built from native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] q64, r64, u64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin
        u64 = sa * sb;
        return u64;
      end
      2'b01: begin
        u64 = {32'b0, a} * {32'b0, b};
        return u64;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hffff_ffff};
        sq = sa / sb;
        sr = sa % sb;
        q64 = sq;
        r64 = sr;
        return {r64[31:0], q64[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hffff_ffff};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Result checker: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_eq("res_hi", {32'b0, hi}, {32'b0, e[63:32]});
        check_eq("res_lo", {32'b0, lo}, {32'b0, e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mt_write(input logic wh, input logic wl, input logic [31:0] data);
    @(negedge clk);
    hi_we = wh; lo_we = wl; wd = data;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (wh) mdl_hi = data;
    if (wl) mdl_lo = data;
    check_eq("mt_hi", {32'b0, hi}, {32'b0, mdl_hi});
    check_eq("mt_lo", {32'b0, lo}, {32'b0, mdl_lo});
    check_eq("mt_no_done", {63'b0, done}, 64'd0);
  endtask

  // mode 0: plain op; 1: start+lo_we while busy; 2: reset at cycle 10;
  // 3: abort at cycle 10.
  task automatic run_op(input logic [1:0] op_i, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [63:0] e;
    logic [31:0] pre_hi, pre_lo;
    int          cyc;
    e = model(op_i, a, b);
    pre_hi = mdl_hi;
    pre_lo = mdl_lo;
    if (mode < 2) begin
      exp_q.push_back(e);
      mdl_hi = e[63:32];
      mdl_lo = e[31:0];
    end
    @(negedge clk);
    start = 1'b1; op = op_i; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0; srca = $urandom; srcb = $urandom; op = 2'($urandom_range(0, 3));
    check_eq("busy_after_start", {63'b0, busy}, 64'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 5 && mode == 1) begin
        start = 1'b1; op = 2'b10; lo_we = 1'b1; hi_we = 1'b1; wd = 32'hdead_beef;
      end
      if (cyc == 10 && mode == 2) reset_n = 1'b0;
`ifdef MULDIV_ABORT_EN
      if (cyc == 10 && mode == 3) abort = 1'b1;
`endif
      @(negedge clk);
      cyc++;
      start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
      if (mode >= 2 && cyc == 11) begin
        reset_n = 1'b1;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        if (mode == 2) begin
          mdl_hi = 32'd0;
          mdl_lo = 32'd0;
        end
        check_eq("flush_busy", {63'b0, busy}, 64'd0);
        check_eq("flush_done", {63'b0, done}, 64'd0);
        check_eq("flush_hi", {32'b0, hi}, {32'b0, mdl_hi});
        check_eq("flush_lo", {32'b0, lo}, {32'b0, mdl_lo});
        break;
      end
      if (done !== 1'b1) check_eq("busy_in_flight", {63'b0, busy}, 64'd1);
      if (cyc == 8) begin
        check_eq("hold_hi", {32'b0, hi}, {32'b0, pre_hi});
        check_eq("hold_lo", {32'b0, lo}, {32'b0, pre_lo});
      end
    end
    if (mode >= 2) begin
      // No done pulse may follow a flush; the checker flags any.
      repeat (40) @(negedge clk);
      check_eq("flush_idle_busy", {63'b0, busy}, 64'd0);
    end else begin
      check_eq("latency", cyc, 33);
      check_eq("busy_at_done", {63'b0, busy}, 64'd0);
      @(negedge clk);
      check_eq("done_one_cycle", {63'b0, done}, 64'd0);
      check_eq("busy_after_done", {63'b0, busy}, 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; op = 2'b00;
    srca = '0; srcb = '0; wd = '0; hi_we = 1'b0; lo_we = 1'b0;
`ifdef MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    mdl_hi = '0; mdl_lo = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'b0, busy}, 64'd0);
    check_eq("rst_done", {63'b0, done}, 64'd0);
    check_eq("rst_hi", {32'b0, hi}, 64'd0);
    check_eq("rst_lo", {32'b0, lo}, 64'd0);
    reset_n = 1'b1;

    mt_write(1'b1, 1'b0, 32'h1234_5678);

    run_op(2'b01, 32'hffff_ffff, 32'hffff_ffff, 0);
    check_eq("multu_max_hi", {32'b0, hi}, {32'b0, 32'hffff_fffe});
    check_eq("multu_max_lo", {32'b0, lo}, {32'b0, 32'h0000_0001});
    run_op(2'b00, 32'hffff_fffd, 32'h0000_0007, 0);
    check_eq("mult_neg_lo", {32'b0, lo}, {32'b0, 32'hffff_ffeb});
    run_op(2'b10, 32'hffff_fff9, 32'h0000_0002, 0);
    check_eq("div_neg_hi", {32'b0, hi}, {32'b0, 32'hffff_ffff});
    run_op(2'b10, 32'h8000_0000, 32'hffff_ffff, 0);
    check_eq("div_ovf_lo", {32'b0, lo}, {32'b0, 32'h8000_0000});
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 0);
    check_eq("divu_zero_hi", {32'b0, hi}, {32'b0, 32'h0000_0064});
    run_op(2'b10, 32'hffff_fffb, 32'h0000_0000, 0);
    run_op(2'b10, 32'h8000_0000, 32'h0000_0000, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b00, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(2'b10, 32'h0000_0007, 32'hffff_fffe, 0);
    run_op(2'b11, 32'hffff_ffff, 32'h8000_0000, 0);

    // start and writes while busy are ignored
    run_op(2'b01, 32'd2, 32'd3, 1);
    check_eq("interfere_hi", {32'b0, hi}, 64'd0);
    check_eq("interfere_lo", {32'b0, lo}, 64'd6);
    repeat (3) @(negedge clk);
    check_eq("interfere_no_restart", {63'b0, busy}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i % 5 == 1) ra = 32'($urandom_range(0, 100)) - 32'd50;
      run_op(2'($urandom_range(0, 3)), ra, rb, 0);
    end

    mt_write(1'b1, 1'b1, 32'hcafe_f00d);
    mt_write(1'b0, 1'b1, 32'h0bad_0bad);

`ifdef MULDIV_ABORT_EN
    run_op(2'b00, 32'h0000_1234, 32'hffff_0000, 3);
    run_op(2'b11, 32'd100, 32'd7, 0);
`endif

    run_op(2'b00, 32'h0000_0123, 32'h0000_0456, 2);

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU. It takes the same srca/srcb operands the ALU takes.
- It produces the HI/LO register pair. HI/LO are read downstream via the mfhi/mflo result mux that feeds writeback.
- It covers MIPS mult, multu, div, divu, mthi and mtlo. The controller stalls on busy.

Parameters:
- WIDTH, 32, operand width and width of HI and LO.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  00 mult, 01 multu, 10 div, 11 divu
- srca  input  WIDTH  multiplicand / dividend
- srcb  input  WIDTH  multiplier / divisor
- hi_we  input  1  mthi write enable
- lo_we  input  1  mtlo write enable
- wd  input  WIDTH  mthi/mtlo write data
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO have been updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state goes to IDLE; busy=0, done=0, hi=0, lo=0; counter and internal registers cleared.
  - Reset takes priority over every other input, including mid-operation. No partial result is written.
- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - If start=1: latch op. Latch |srca| and |srcb| for signed ops, raw values for unsigned ops. Record the result signs. Set counter=0, busy=1, go to CALC.
  - Else apply hi_we/lo_we: hi<=wd, lo<=wd independently; both may be asserted together.
  - start and hi_we/lo_we in the same cycle: start wins; the writes are dropped.
- CALC: one radix-2 step per cycle, WIDTH cycles total (counter 0..WIDTH-1).
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After the last step, go to FIX.
- FIX: apply sign correction and write hi/lo. Then done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: start sampled at edge 0. hi/lo and done are valid after edge WIDTH+1 (edge 33 at default). busy is high after edges 0..WIDTH and low after edge WIDTH+1.
- While busy: start, hi_we and lo_we are ignored; hi/lo hold their prior values until FIX.
- Operands: srca/srcb may change after the start edge without effect.
- Multiply results: hi = upper WIDTH bits and lo = lower WIDTH bits of the full 2*WIDTH product.
  - Signed: product negated (two's complement over 2*WIDTH bits) if the operand signs differ.
- Divide results: lo = quotient, hi = remainder, truncating toward zero.
  - Signed: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
- Divide by zero (div or divu): lo = all ones, hi = srca as latched (original signed value, not its magnitude). Latency is unchanged.
- Signed overflow, div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Magnitude of the most negative value: computed as an unsigned WIDTH-bit value (0x80000000). No extra width is required.
- done is never asserted for mthi/mtlo writes.

Optional Feature:
- Macro MULDIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit), placed after op.
  - abort=1 in CALC or FIX: state goes to IDLE at that edge, busy=0, done stays 0, hi/lo unchanged. Used for exception flush.
  - abort in IDLE has no effect; start in the same cycle still begins an operation.
- Not defined: no abort port; an operation always runs to completion unless reset_n=0.

Test Plan:
- multu srca=0xFFFFFFFF srcb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly one cycle, 33 edges after the start edge; busy high for edges 0..32.
- mult srca=0xFFFFFFFD (-3) srcb=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- div srca=0xFFFFFFF9 (-7) srcb=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- divu srca=0x00000064 srcb=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- mthi 0x12345678 in IDLE -> hi=0x12345678, done=0. start multu 2*3, then assert start (op=div) and lo_we at cycle 5 -> both ignored; final hi=0, lo=6.
- Start mult, drive reset_n=0 at cycle 10 -> next edge busy=0, done=0, hi=lo=0. No done pulse follows. With MULDIV_ABORT_EN, abort at cycle 10 -> busy=0 and hi/lo keep their pre-start values.
